// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the catch-the-fruit game timer
package game_pkg;

  // Timer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  // Width of one BCD digit
  localparam int BCD_W = 4;

  // Largest legal BCD digit; also the value a digit takes after a borrow
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD digit: borrow-chained decrement, load clamp and zero flag
module bcd_down_digit
  import game_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             borrow_in_i,
  input  logic [BCD_W-1:0] load_digit_i,
  output logic [BCD_W-1:0] dec_digit_o,
  output logic             borrow_out_o,
  output logic [BCD_W-1:0] clamp_digit_o,
  output logic             zero_o
);

  // Decrement when borrowed from; a zero digit rolls to 9 and passes the borrow on
  always_comb begin
    dec_digit_o  = digit_i;
    borrow_out_o = 1'b0;
    if (borrow_in_i) begin
      if (digit_i == '0) begin
        dec_digit_o  = BCD_MAX;
        borrow_out_o = 1'b1;
      end else begin
        dec_digit_o = digit_i - 1'b1;
      end
    end
  end

  // Non-BCD codes on load are forced to 9 so the count is always legal BCD
  always_comb begin
    clamp_digit_o = (load_digit_i > BCD_MAX) ? BCD_MAX : load_digit_i;
    zero_o        = (digit_i == '0);
  end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - BCD countdown timer with start/pause/load and done handshake; optional warn via GAME_TIMER_WARN_EN
module game_timer
  import game_pkg::*;
#(
  parameter int                   CLK_HZ      = 50_000_000,
  parameter int                   TICK_HZ     = 1,
  parameter int                   DIGITS      = 2,
  parameter logic [4*DIGITS-1:0]  START_VALUE = 'h60,
  parameter logic [4*DIGITS-1:0]  WARN_VALUE  = 'h10
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tick,
  output logic                  running,
  output logic                  done,
  output logic                  done_pulse,
  output logic                  warn
);

  localparam int             W        = BCD_W * DIGITS;
  localparam int             DIV      = CLK_HZ / TICK_HZ;
  localparam int             DIV_W    = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  timer_state_t     state_q, state_d;
  logic [W-1:0]     count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             done_pulse_q, done_pulse_d;

  logic [W-1:0]     dec_count;
  logic [W-1:0]     clamp_count;
  logic [DIGITS:0]  borrow;
  logic [DIGITS-1:0] zero;
  logic             count_is_zero;
  logic             count_is_one;

  // Decrement always subtracts one from digit 0; borrows ripple upward
  assign borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
        .digit_i       (count_q[g*BCD_W +: BCD_W]),
        .borrow_in_i   (borrow[g]),
        .load_digit_i  (load_value[g*BCD_W +: BCD_W]),
        .dec_digit_o   (dec_count[g*BCD_W +: BCD_W]),
        .borrow_out_o  (borrow[g+1]),
        .clamp_digit_o (clamp_count[g*BCD_W +: BCD_W]),
        .zero_o        (zero[g])
      );
    end
  endgenerate

  assign count_is_zero = &zero;
  assign count_is_one  = (count_q == W'(1));

  // Next-state: load beats start beats pause; divider runs only while in RUN
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    div_d        = div_q;
    tick_d       = 1'b0;
    done_pulse_d = 1'b0;
    if (load) begin
      count_d = clamp_count;
      div_d   = '0;
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      case (state_q)
        IDLE: begin
          div_d = '0;
          if (count_is_zero) begin
            state_d      = DONE;
            done_pulse_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        PAUSED: state_d = RUN;
        DONE: begin
          count_d = START_VALUE;
          div_d   = '0;
          state_d = RUN;
        end
        default: state_d = state_q;
      endcase
    end else if (state_q == RUN) begin
      // The pause edge still counts the cycle just spent in RUN
      if (div_q == DIV_LAST) begin
        div_d = '0;
        // A borrow out of the top digit would mean wrapping below zero
        if (!borrow[DIGITS]) begin
          count_d = dec_count;
          tick_d  = 1'b1;
          if (count_is_one) begin
            state_d      = DONE;
            done_pulse_d = 1'b1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
      if (pause && (state_d == RUN)) begin
        state_d = PAUSED;
      end
    end
  end

  // State, count, divider and strobe registers
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q      <= IDLE;
      count_q      <= START_VALUE;
      div_q        <= '0;
      tick_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bcd_out    = count_q;
  assign tick       = tick_q;
  assign done_pulse = done_pulse_q;
  assign running    = (state_q == RUN);
  assign done       = (state_q == DONE);

`ifdef GAME_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Packed BCD orders the same as its decimal value, so an unsigned compare is a BCD magnitude compare
  always_comb begin
    warn_d = (state_d != IDLE) && (count_d <= WARN_VALUE);
  end

  // Warn register tracks the count register
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - directed table and sequence bench for game_timer (DIV=10, start 'h12, warn 'h05)
module tb_game_timer;

`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0, ld = 1'b0, st = 1'b0, ps = 1'b0;
  logic [7:0] lv  = 8'h00;
  logic [7:0] bcd;
  logic       tick, running, done, done_pulse, warn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_timer #(
    .CLK_HZ      (10),
    .TICK_HZ     (1),
    .DIGITS      (2),
    .START_VALUE (8'h12),
    .WARN_VALUE  (8'h05)
  ) dut (
    .CLOCK_50   (clk),
    .Reset      (rst),
    .start      (st),
    .pause      (ps),
    .load       (ld),
    .load_value (lv),
    .bcd_out    (bcd),
    .tick       (tick),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse),
    .warn       (warn)
  );

  typedef struct {
    logic       rst, ld, st, ps;
    logic [7:0] lv;
    logic [7:0] e_bcd;
    logic       e_run, e_done, e_dp, e_tick, e_warn;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic s, input logic p, input logic [7:0] v);
    rst = r; ld = l; st = s; ps = p; lv = v;
    @(posedge clk);
    #1;
    rst = 1'b0; ld = 1'b0; st = 1'b0; ps = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00);
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_bcd, input logic e_run,
                           input logic e_done, input logic e_dp, input logic e_tick, input logic e_warn);
    check({tag, ".bcd"},        32'(bcd),        32'(e_bcd));
    check({tag, ".running"},    32'(running),    32'(e_run));
    check({tag, ".done"},       32'(done),       32'(e_done));
    check({tag, ".done_pulse"}, 32'(done_pulse), 32'(e_dp));
    check({tag, ".tick"},       32'(tick),       32'(e_tick));
    check({tag, ".warn"},       32'(warn),       32'(e_warn && WARN_ON));
  endtask

  vec_t vt [12];

  initial begin
    //            rst ld st ps  lv     bcd    run done dp tick warn
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3A, 8'h39, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h39, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);

    // Single-edge control behaviour
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].rst, vt[i].ld, vt[i].st, vt[i].ps, vt[i].lv);
      check_all($sformatf("vec%0d", i), vt[i].e_bcd, vt[i].e_run, vt[i].e_done,
                vt[i].e_dp, vt[i].e_tick, vt[i].e_warn);
    end

    // Full countdown from 'h12 to DONE
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    check_all("run.k0", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 122; k++) begin
      int n;
      idle(1);
      n = 12 - ((k > 120 ? 120 : k) / 10);
      check_all($sformatf("run.k%0d", k), 8'((n / 10) * 16 + (n % 10)),
                k < 120, k >= 120, k == 120, (k <= 120) && (k % 10 == 0), k >= 70);
    end

    // Borrow across digits
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h20);
    cyc(0, 0, 1, 0, 8'h00);
    idle(10);
    check_all("borrow.19", 8'h19, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    check_all("borrow.18", 8'h18, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Pause after 5 cycles, hold 7, resume: next decrement 5 cycles later
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    idle(4);
    cyc(0, 0, 0, 1, 8'h00);
    check_all("pause.enter", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(7);
    check_all("pause.hold", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 8'h00);
    check_all("pause.resume", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    check_all("pause.r4", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_all("pause.r5", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-run at 'h07
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    idle(50);
    check_all("midrun.07", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1, 0, 1, 0, 8'h00);
    check_all("midrun.reset", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
